// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants for the 8:1 mux select sequencer.
// Holds default widths, the FSM state encoding and the first/last select
// positions, which depend on the serial bit order (MUX_SEQ_MSB_FIRST_EN).
package mux_sel_sequencer_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int PKG_SEL_W  = 3;
  localparam int PKG_WCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select position of the first serial bit of a word.
  function automatic int sel_first(input int data_w);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return data_w - 1;
`else
    return 0;
`endif
  endfunction

  // Select position of the last serial bit of a word.
  function automatic int sel_last(input int data_w);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 0;
`else
    return data_w - 1;
`endif
  endfunction

endpackage

// File: rtl/mux_sel_sequencer.sv
// Upstream control stage for an 8:1 mux: latches a parallel word and sweeps
// the mux select once per clock so the mux output becomes a serial bitstream.
// Latency: first bit_valid one cycle after acceptance; back-to-back words with
// no bubble. Backpressure: in_ready only in IDLE or on an unstalled last bit;
// hold freezes the sweep.
// Ports: clk/rst_n (sync active-low), in_data/in_valid/in_ready word input,
// hold stall, mux_in/mux_sel mux drive, bit_valid/word_done/word_cnt framing.
// Build option: MUX_SEQ_MSB_FIRST_EN sends MSB first (select decrements).
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,  // must equal 2**SEL_W
  parameter int SEL_W  = PKG_SEL_W,
  parameter int WCNT_W = PKG_WCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              bit_valid,
  output logic              word_done,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam logic [SEL_W-1:0] FIRST = SEL_W'(sel_first(DATA_W));
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(sel_last(DATA_W));

  state_t            r_state;
  logic [DATA_W-1:0] r_mux_in;
  logic [SEL_W-1:0]  r_mux_sel;
  logic              r_bit_valid;
  logic [WCNT_W-1:0] r_word_cnt;

  logic              w_step;
  logic              w_last;
  logic              w_ready;
  logic [SEL_W-1:0]  w_sel_next;

  // The select wraps modulo 2**SEL_W, so stepping past LAST lands on FIRST.
`ifdef MUX_SEQ_MSB_FIRST_EN
  assign w_sel_next = r_mux_sel - SEL_W'(1);
`else
  assign w_sel_next = r_mux_sel + SEL_W'(1);
`endif

  assign w_step  = (r_state == SHIFT) && !hold;
  assign w_last  = w_step && (r_mux_sel == LAST);
  // Ready on the last bit lets the next word follow with no bubble.
  assign w_ready = (r_state == IDLE) || w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mux_in    <= '0;
      r_mux_sel   <= '0;
      r_bit_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mux_in    <= in_data;
            r_mux_sel   <= FIRST;
            r_state     <= SHIFT;
            r_bit_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (r_mux_sel == LAST) begin
              r_word_cnt <= r_word_cnt + WCNT_W'(1);
              r_mux_sel  <= FIRST;
              if (in_valid) begin
                r_mux_in <= in_data;
              end else begin
                r_state     <= IDLE;
                r_bit_valid <= 1'b0;
              end
            end else begin
              r_mux_sel <= w_sel_next;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_bit_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign word_done = w_last;
  assign mux_in    = r_mux_in;
  assign mux_sel   = r_mux_sel;
  assign bit_valid = r_bit_valid;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model (busy flag, word, bit position).
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       hold;
  logic [7:0] mux_in;
  logic [2:0] mux_sel;
  logic       bit_valid;
  logic       word_done;
  logic [7:0] word_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .WCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .hold(hold), .mux_in(mux_in), .mux_sel(mux_sel),
    .bit_valid(bit_valid), .word_done(word_done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: is a word in flight, which word, how many of its bits
  // have already been presented, and completed words mod 256.
  bit         m_busy = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_pos  = 0;
  int         m_cnt  = 0;
  bit         chk_en = 1'b0;
  bit         rx_bits[$];

  // Select position that carries the p-th transmitted bit.
  function automatic int order(input int p);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 7 - p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("comparison %s mismatched", tag);
    end
  endtask

  // One clock: drive at negedge, compare just after, update model at posedge.
  task automatic step(input bit v, input logic [7:0] d, input bit h, input bit r);
    bit last;
    @(negedge clk);
    in_valid = v; in_data = d; hold = h; rst_n = r;
    #1;
    last = m_busy && (m_pos == 7) && !h;
    if (chk_en) begin
      chk("bit_valid", int'(bit_valid), int'(m_busy));
      chk("in_ready",  int'(in_ready),  int'(!m_busy || last));
      chk("word_done", int'(word_done), int'(last));
      chk("word_cnt",  int'(word_cnt),  m_cnt);
      if (m_busy) begin
        chk("mux_sel", int'(mux_sel), order(m_pos));
        chk("mux_in",  int'(mux_in),  int'(m_word));
        chk("serial",  int'((mux_in >> mux_sel) & 8'h01), int'((m_word >> order(m_pos)) & 8'h01));
      end
    end
    if (bit_valid === 1'b1 && !h) rx_bits.push_back(mux_in[mux_sel]);
    @(posedge clk);
    if (!r) begin
      m_busy = 1'b0; m_word = 8'h00; m_pos = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (v) begin m_busy = 1'b1; m_word = d; m_pos = 0; end
    end else if (!h) begin
      if (m_pos == 7) begin
        m_cnt = (m_cnt + 1) % 256;
        if (v) begin m_word = d; m_pos = 0; end
        else m_busy = 1'b0;
      end else begin
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic reset_check();
    chk("rst_mux_sel",   int'(mux_sel),   0);
    chk("rst_mux_in",    int'(mux_in),    0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_word_done", int'(word_done), 0);
    chk("rst_word_cnt",  int'(word_cnt),  0);
    chk("rst_in_ready",  int'(in_ready),  1);
  endtask

  // Offer words with in_valid held, advancing to the next word on acceptance.
  task automatic send_stream(input logic [7:0] words[$], input int hold_pct);
    int idx = 0;
    bit v, h, acc;
    logic [7:0] d;
    for (int guard = 0; guard < 20000; guard++) begin
      if (idx >= words.size() && !m_busy) break;
      v = (idx < words.size());
      d = v ? words[idx] : 8'h00;
      h = ($urandom_range(99) < hold_pct);
      acc = v && (!m_busy || (m_pos == 7 && !h));
      step(v, d, h, 1'b1);
      if (acc) idx++;
    end
    chk("stream_drained", idx, words.size());
  endtask

  function automatic logic [7:0] rebuild();
    logic [7:0] w = 8'h00;
    for (int k = 0; k < 8; k++) w[order(k)] = rx_bits[k];
    return w;
  endfunction

  initial begin
    logic [7:0] q[$];
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; hold = 1'b0;

    // Reset
    step(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    step(0, 8'h00, 0, 0);
    reset_check();

    // Single word 8'hA5, then idle
    rx_bits.delete();
    step(1, 8'hA5, 0, 1);
    repeat (10) step(0, 8'h00, 0, 1);
    chk("a5_bits", rx_bits.size(), 8);
    if (rx_bits.size() >= 8) chk("a5_serial", int'(rebuild()), 8'hA5);
    chk("a5_cnt", int'(word_cnt), 1);

    // Back-to-back FF then 00
    q = '{8'hFF, 8'h00};
    send_stream(q, 0);
    chk("b2b_cnt", int'(word_cnt), 3);

    // Hold for 3 cycles after three bits have been presented
    rx_bits.delete();
    step(1, 8'h3C, 0, 1);
    repeat (3) step(0, 8'h00, 0, 1);
    repeat (3) step(0, 8'h00, 1, 1);
    chk("hold_sel", int'(mux_sel), order(3));
    repeat (8) step(0, 8'h00, 0, 1);
    chk("hold_bits", rx_bits.size(), 8);
    if (rx_bits.size() >= 8) chk("hold_serial", int'(rebuild()), 8'h3C);

    // Reset mid-word with five bits presented
    step(1, 8'h96, 0, 1);
    repeat (5) step(0, 8'h00, 0, 1);
    step(1, 8'h55, 0, 0);
    reset_check();
    repeat (2) step(0, 8'h00, 0, 1);

    // 256 back-to-back words: counter wraps to its starting value
    step(1, 8'h11, 0, 1);
    repeat (9) step(0, 8'h00, 0, 1);
    c0 = m_cnt;
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    send_stream(q, 0);
    chk("wrap_cnt", int'(word_cnt), c0);

    // Random traffic with holds and occasional resets
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(2) != 0), 8'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(199) != 0));
    repeat (12) step(0, 8'h00, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
